// File: rtl/brisc_store_buffer.sv
// brisc_store_buffer: in-order FIFO of committed stores with load forwarding.
// The youngest store to the same word decides whether a load hits or stalls.
module brisc_store_buffer #(
    parameter int N_ENTRIES = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           st_valid_i,
    input  logic [ADDR_W-1:0]              st_addr_i,
    input  logic [DATA_W-1:0]              st_data_i,
    input  logic                           st_byte_i,
    output logic                           st_ready_o,
    input  logic                           ld_valid_i,
    input  logic [ADDR_W-1:0]              ld_addr_i,
    input  logic                           ld_byte_i,
    output logic                           ld_hit_o,
    output logic [DATA_W-1:0]              ld_data_o,
    output logic                           ld_stall_o,
    output logic                           drain_valid_o,
    output logic [ADDR_W-1:0]              drain_addr_o,
    output logic [DATA_W-1:0]              drain_data_o,
    output logic                           drain_byte_o,
    input  logic                           drain_ready_i,
    output logic [$clog2(N_ENTRIES):0]     count_o,
    output logic                           empty_o
);
    localparam int PW = $clog2(N_ENTRIES);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [N_ENTRIES];
    logic [DATA_W-1:0] data_q [N_ENTRIES];
    logic              byte_q [N_ENTRIES];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;

    assign count_o       = count;
    assign empty_o       = (count == '0);
    assign st_ready_o    = (count < CW'(N_ENTRIES));
    assign drain_valid_o = !empty_o;
    assign drain_addr_o  = addr_q[head];
    assign drain_data_o  = data_q[head];
    assign drain_byte_o  = byte_q[head];
    assign push          = st_valid_i && st_ready_o;
    assign pop           = drain_valid_o && drain_ready_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Payloads carry no reset; occupancy alone says which slots are live.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[tail] <= st_addr_i;
            data_q[tail] <= st_data_i;
            byte_q[tail] <= st_byte_i;
        end
    end

    logic          found;
    logic [PW-1:0] m_idx;
    logic [PW-1:0] idx;
    logic [7:0]    lane;

    // Walk oldest to youngest so the last match is the youngest one.
    always_comb begin
        found = 1'b0;
        m_idx = head;
        idx   = head;
        for (int i = 0; i < N_ENTRIES; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count &&
                addr_q[idx][ADDR_W-1:2] == ld_addr_i[ADDR_W-1:2]) begin
                found = 1'b1;
                m_idx = idx;
            end
        end
    end

    always_comb begin
        ld_hit_o   = 1'b0;
        ld_stall_o = 1'b0;
        ld_data_o  = '0;
        lane = 8'(data_q[m_idx] >> {ld_addr_i[1:0], 3'b000});
        if (ld_valid_i && found) begin
            if (!ld_byte_i) begin
                if (byte_q[m_idx]) begin
                    ld_stall_o = 1'b1;
                end else begin
                    ld_hit_o  = 1'b1;
                    ld_data_o = data_q[m_idx];
                end
            end else if (!byte_q[m_idx]) begin
                ld_hit_o  = 1'b1;
                ld_data_o = DATA_W'(lane);
            end else if (addr_q[m_idx][1:0] == ld_addr_i[1:0]) begin
                ld_hit_o  = 1'b1;
                ld_data_o = DATA_W'(data_q[m_idx][7:0]);
            end else begin
                ld_stall_o = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brisc_store_buffer.sv
// Bench for brisc_store_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_brisc_store_buffer;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid_i = 1'b0;
    logic [31:0] st_addr_i = '0;
    logic [31:0] st_data_i = '0;
    logic        st_byte_i = 1'b0;
    logic        st_ready_o;
    logic        ld_valid_i = 1'b0;
    logic [31:0] ld_addr_i = '0;
    logic        ld_byte_i = 1'b0;
    logic        ld_hit_o;
    logic [31:0] ld_data_o;
    logic        ld_stall_o;
    logic        drain_valid_o;
    logic [31:0] drain_addr_o;
    logic [31:0] drain_data_o;
    logic        drain_byte_o;
    logic        drain_ready_i = 1'b0;
    logic [2:0]  count_o;
    logic        empty_o;

    int n_checks = 0;
    int n_fail = 0;

    brisc_store_buffer #(.N_ENTRIES(N), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid_i(st_valid_i), .st_addr_i(st_addr_i),
        .st_data_i(st_data_i), .st_byte_i(st_byte_i),
        .st_ready_o(st_ready_o),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i),
        .ld_byte_i(ld_byte_i), .ld_hit_o(ld_hit_o),
        .ld_data_o(ld_data_o), .ld_stall_o(ld_stall_o),
        .drain_valid_o(drain_valid_o), .drain_addr_o(drain_addr_o),
        .drain_data_o(drain_data_o), .drain_byte_o(drain_byte_o),
        .drain_ready_i(drain_ready_i),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        b;
    } ent_t;

    ent_t        q[$];
    logic [31:0] drained[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_ld(input logic v, input logic [31:0] a,
                                     input logic b, output logic h,
                                     output logic s, output logic [31:0] d);
        h = 1'b0;
        s = 1'b0;
        d = '0;
        if (!v) return;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a[31:2] == a[31:2]) begin
                if (!b) begin
                    if (q[i].b) s = 1'b1;
                    else begin h = 1'b1; d = q[i].d; end
                end else if (!q[i].b) begin
                    h = 1'b1;
                    d = (q[i].d >> (8 * a[1:0])) & 32'hFF;
                end else if (q[i].a[1:0] == a[1:0]) begin
                    h = 1'b1;
                    d = {24'd0, q[i].d[7:0]};
                end else begin
                    s = 1'b1;
                end
                return;
            end
        end
    endfunction

    // Reference model: decide push/pop from the queue depth before updating.
    always @(posedge clk or posedge reset) begin : model_upd
        bit do_pop, do_push;
        ent_t e;
        if (reset) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && drain_ready_i;
            do_push = st_valid_i && (q.size() < N);
            e.a = st_addr_i;
            e.d = st_data_i;
            e.b = st_byte_i;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
    end

    always @(negedge clk) begin : compare
        logic        eh, es;
        logic [31:0] ed;
        chk("st_ready", 32'(st_ready_o), 32'(q.size() < N));
        chk("count", 32'(count_o), 32'(q.size()));
        chk("empty", 32'(empty_o), 32'(q.size() == 0));
        chk("drain_valid", 32'(drain_valid_o), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("drain_addr", drain_addr_o, q[0].a);
            chk("drain_data", drain_data_o, q[0].d);
            chk("drain_byte", 32'(drain_byte_o), 32'(q[0].b));
        end
        model_ld(ld_valid_i, ld_addr_i, ld_byte_i, eh, es, ed);
        chk("ld_hit", 32'(ld_hit_o), 32'(eh));
        chk("ld_stall", 32'(ld_stall_o), 32'(es));
        chk("ld_data", ld_data_o, ed);
        chk("hit_stall_excl", 32'(ld_hit_o && ld_stall_o), 32'(0));
    end

    always @(negedge clk) begin
        if (!reset && drain_valid_o && drain_ready_i)
            drained.push_back(drain_addr_o);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d,
                         input logic b);
        st_valid_i = 1'b1;
        st_addr_i  = a;
        st_data_i  = d;
        st_byte_i  = b;
        cyc();
        st_valid_i = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] a, input logic b);
        ld_valid_i = 1'b1;
        ld_addr_i  = a;
        ld_byte_i  = b;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int k;
        int nlog;
        logic acc;

        ld_valid_i = 1'b1;
        ld_addr_i  = 32'h100;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_ready", 32'(st_ready_o), 32'(1));
        chk("rst_drain_valid", 32'(drain_valid_o), 32'(0));
        chk("rst_count", 32'(count_o), 32'(0));
        chk("rst_empty", 32'(empty_o), 32'(1));
        chk("rst_ld_hit", 32'(ld_hit_o), 32'(0));
        reset = 1'b0;
        ld_valid_i = 1'b0;
        cyc();

        // Fill, reject a fifth store, then drain in order.
        for (int i = 0; i < 4; i++)
            store(32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
        chk("full_count", 32'(count_o), 32'(4));
        chk("full_st_ready", 32'(st_ready_o), 32'(0));
        st_valid_i = 1'b1;
        st_addr_i  = 32'h110;
        st_data_i  = 32'hBAD;
        cyc();
        st_valid_i = 1'b0;
        chk("fifth_ignored", 32'(count_o), 32'(4));
        drained.delete();
        drain_ready_i = 1'b1;
        repeat (4) cyc();
        drain_ready_i = 1'b0;
        chk("drained_empty", 32'(empty_o), 32'(1));
        chk("drain_n", 32'(drained.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            chk("drain_order", drained[i], 32'h100 + 32'(4 * i));

        // Youngest word store wins; byte extraction from a word entry.
        store(32'h200, 32'hAABBCCDD, 1'b0);
        store(32'h200, 32'h11223344, 1'b0);
        lookup(32'h200, 1'b0);
        chk("lw_young_hit", 32'(ld_hit_o), 32'(1));
        chk("lw_young_data", ld_data_o, 32'h11223344);
        lookup(32'h201, 1'b1);
        chk("lb_word_hit", 32'(ld_hit_o), 32'(1));
        chk("lb_word_data", ld_data_o, 32'h00000033);
        drain_ready_i = 1'b1;
        cyc();
        #1;
        chk("pop_head_hit", 32'(ld_hit_o), 32'(1));
        chk("pop_head_data", ld_data_o, 32'h00000033);
        cyc();
        drain_ready_i = 1'b0;
        ld_valid_i = 1'b0;
        chk("e040_empty", 32'(empty_o), 32'(1));

        // Byte store over a word: same byte hits, others stall.
        store(32'h300, 32'hDEADBEEF, 1'b0);
        store(32'h302, 32'h12345655, 1'b1);
        lookup(32'h302, 1'b1);
        chk("sb_same_hit", 32'(ld_hit_o), 32'(1));
        chk("sb_same_data", ld_data_o, 32'h00000055);
        lookup(32'h300, 1'b0);
        chk("lw_over_sb_stall", 32'(ld_stall_o), 32'(1));
        chk("lw_over_sb_hit", 32'(ld_hit_o), 32'(0));
        lookup(32'h301, 1'b1);
        chk("lb_other_stall", 32'(ld_stall_o), 32'(1));
        cyc();
        lookup(32'h404, 1'b1);
        chk("miss_hit", 32'(ld_hit_o), 32'(0));
        chk("miss_stall", 32'(ld_stall_o), 32'(0));
        chk("miss_data", ld_data_o, 32'h0);
        ld_valid_i = 1'b0;
        drain_ready_i = 1'b1;
        repeat (2) cyc();
        drain_ready_i = 1'b0;

        // Full with store and drain together, then wrap over ten stores.
        drained.delete();
        for (int i = 0; i < 4; i++)
            store(32'h500 + 32'(4 * i), 32'h500 + 32'(4 * i), 1'b0);
        st_valid_i = 1'b1;
        st_addr_i  = 32'h510;
        st_data_i  = 32'h510;
        st_byte_i  = 1'b0;
        drain_ready_i = 1'b1;
        #1;
        chk("full_both_ready", 32'(st_ready_o), 32'(0));
        cyc();
        chk("full_both_count", 32'(count_o), 32'(3));
        drain_ready_i = 1'b0;
        cyc();
        chk("refill_count", 32'(count_o), 32'(4));
        k = 5;
        drain_ready_i = 1'b1;
        for (int c = 0; c < 100 && k < 10; c++) begin
            st_addr_i = 32'h500 + 32'(4 * k);
            st_data_i = 32'h500 + 32'(4 * k);
            st_valid_i = 1'b1;
            acc = st_ready_o;
            cyc();
            if (acc) k++;
        end
        st_valid_i = 1'b0;
        for (int c = 0; c < 20 && !empty_o; c++) cyc();
        drain_ready_i = 1'b0;
        chk("wrap_n", 32'(drained.size()), 32'(10));
        for (int i = 0; i < 10; i++)
            chk("wrap_order", drained[i], 32'h500 + 32'(4 * i));

        // Asynchronous reset in mid-cycle with two entries held.
        store(32'h600, 32'h66, 1'b0);
        store(32'h604, 32'h67, 1'b0);
        lookup(32'h600, 1'b0);
        chk("pre_rst_hit", 32'(ld_hit_o), 32'(1));
        nlog = drained.size();
        @(posedge clk);
        #2;
        reset = 1'b1;
        drain_ready_i = 1'b1;
        #1;
        chk("arst_st_ready", 32'(st_ready_o), 32'(1));
        chk("arst_drain_valid", 32'(drain_valid_o), 32'(0));
        chk("arst_hit", 32'(ld_hit_o), 32'(0));
        chk("arst_stall", 32'(ld_stall_o), 32'(0));
        chk("arst_data", ld_data_o, 32'h0);
        chk("arst_count", 32'(count_o), 32'(0));
        chk("arst_empty", 32'(empty_o), 32'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc();
        drain_ready_i = 1'b0;
        chk("post_rst_no_drain", 32'(drained.size()), 32'(nlog));
        chk("post_rst_hit", 32'(ld_hit_o), 32'(0));
        chk("post_rst_count", 32'(count_o), 32'(0));
        ld_valid_i = 1'b0;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/brisc_store_buffer.md
BRISC_STORE_BUFFER -- requirements
Module: brisc_store_buffer

Interface
REQ-001 Parameter N_ENTRIES, default 4, buffer depth; SHALL be a power of two, minimum 2.
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, store data width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 st_valid_i  in  1  committed store presented.
REQ-007 st_addr_i  in  ADDR_W  store byte address.
REQ-008 st_data_i  in  DATA_W  store data; SB uses [7:0].
REQ-009 st_byte_i  in  1  1 = SB, 0 = SW.
REQ-010 st_ready_o  out  1  buffer can accept a store.
REQ-011 ld_valid_i  in  1  load lookup request.
REQ-012 ld_addr_i  in  ADDR_W  load byte address.
REQ-013 ld_byte_i  in  1  1 = LB, 0 = LW.
REQ-014 ld_hit_o  out  1  forwarded data valid.
REQ-015 ld_data_o  out  DATA_W  forwarded data.
REQ-016 ld_stall_o  out  1  overlap that cannot be forwarded; load must retry.
REQ-017 drain_valid_o  out  1  oldest entry offered to cache.
REQ-018 drain_addr_o / drain_data_o / drain_byte_o  out  ADDR_W / DATA_W / 1  oldest entry contents.
REQ-019 drain_ready_i  in  1  cache accepts drain this cycle.
REQ-020 count_o  out  $clog2(N_ENTRIES)+1  occupied entries.
REQ-021 empty_o  out  1  count_o == 0.

Function
REQ-022 Circular FIFO; head (oldest) and tail pointers wrap modulo N_ENTRIES.
REQ-023 Enqueue SHALL occur when st_valid_i && st_ready_o; entry written at tail, tail increments.
REQ-024 st_ready_o SHALL be (count_o < N_ENTRIES), registered-state only; no combinational path from drain_ready_i.
REQ-025 drain_valid_o SHALL equal !empty_o; drain_* SHALL show the head entry; pop when drain_valid_o && drain_ready_i.
REQ-026 Simultaneous enqueue and pop: both occur, count_o unchanged.
REQ-027 A store enqueued at edge N SHALL be visible on drain_* and to lookup from cycle N+1; zero-cycle bypass not permitted.
REQ-028 drain_* SHALL hold stable while drain_valid_o && !drain_ready_i.
REQ-029 Lookup is combinational over all occupied entries; the youngest entry with matching word address (addr[ADDR_W-1:2]) decides.
REQ-030 LW: youngest match SW -> ld_hit_o=1, ld_data_o = entry data; youngest match SB -> ld_stall_o=1.
REQ-031 LB: youngest match SW -> hit, ld_data_o[7:0] = byte addr[1:0] of entry data, upper bits 0; youngest match SB with identical byte address -> hit, ld_data_o[7:0] = entry [7:0]; SB other byte -> ld_stall_o=1.
REQ-032 No match, or ld_valid_i=0 -> ld_hit_o=0, ld_stall_o=0, ld_data_o=0.
REQ-033 ld_hit_o and ld_stall_o SHALL never both be 1.
REQ-034 Head entry being popped this cycle SHALL still participate in lookup this cycle.
REQ-035 Store presented while full SHALL be ignored (st_ready_o=0); core holds it.

Reset
REQ-036 reset SHALL asynchronously clear head, tail, count; entry payloads need no reset.
REQ-037 During and after reset: st_ready_o=1, drain_valid_o=0, ld_hit_o=0, ld_stall_o=0, ld_data_o=0, count_o=0, empty_o=1.
REQ-038 Reset mid-operation SHALL discard all pending stores; no drain handshake completes in the reset cycle.

Verification
REQ-039 N=4, drain_ready_i=0, 4 SW to 0x100..0x10C -> count_o 4, st_ready_o 0; 5th store ignored; set drain_ready_i=1 -> drains 0x100,0x104,0x108,0x10C in order, empty_o=1.
REQ-040 SW 0x200=0xAABBCCDD then SW 0x200=0x11223344; LW 0x200 -> hit, 0x11223344; LB 0x201 -> hit, 0x00000033.
REQ-041 SW 0x300=0xDEADBEEF then SB 0x302=0x55; LB 0x302 -> hit 0x55; LW 0x300 -> stall; LB 0x301 -> stall.
REQ-042 Full buffer, st_valid_i and drain_ready_i both 1 -> st_ready_o 0, one pop, count_o 3; next cycle store accepted, count_o 4; tail wrap verified by drain order over 10 stores.
REQ-043 Two entries held, assert reset asynchronously mid-cycle -> outputs take REQ-037 values immediately; after release, LW of prior address -> no hit.
